y_wrr_arbiter: RTL and testbench

Y_WRR_ARBITER -- requirements
Module: y_wrr_arbiter

---
 rtl/y_arb_pkg.sv | 20 ++
 rtl/y_prio_pick.sv | 30 +++
 rtl/y_wrr_arbiter.sv | 128 ++++++++++++
 tb/tb_y_wrr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y_arb_pkg.sv
// Shared types and default sizes for the column
// weighted round-robin arbiter.
package y_arb_pkg;

  localparam int Y_ARB_WIDTH = 8;
  localparam int Y_ARB_WGT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_HOLD,
    ST_DONE
  } arb_state_e;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/y_prio_pick.sv
// Lowest-index picker: one-hot grant, binary index, any.
// Ports: req_i in; gnt_o, idx_o, any_o out (combinational).
module y_prio_pick
  import y_arb_pkg::*;
#(
  parameter int WIDTH   = Y_ARB_WIDTH,
  parameter int Y_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   req_i,
  output logic [WIDTH-1:0]   gnt_o,
  output logic [Y_WIDTH-1:0] idx_o,
  output logic               any_o
);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = Y_WIDTH'(i);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/y_wrr_arbiter.sv
// Column arbiter: round-robin scan or fixed priority, with a
// valid/ready grant handshake and a one-cycle scan_done_o pulse.
// Ports: clk_i, reset_i (sync, active high), enable_i, req_i,
//   mode_i, weight_i, gnt_ready_i in; gnt_o, yadd_o,
//   gnt_valid_o, scan_done_o out (all registered).
// Macro Y_WRR_ARBITER_WEIGHT_EN: per-column burst credits
//   from weight_i; undefined = one transfer per grant.
module y_wrr_arbiter
  import y_arb_pkg::*;
#(
  parameter int WIDTH   = Y_ARB_WIDTH,
  parameter int Y_WIDTH = $clog2(WIDTH),
  parameter int WGT_W   = Y_ARB_WGT_W
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [WIDTH-1:0]       req_i,
  input  logic                   mode_i,
  input  logic [WIDTH*WGT_W-1:0] weight_i,
  output logic [WIDTH-1:0]       gnt_o,
  output logic [Y_WIDTH-1:0]     yadd_o,
  output logic                   gnt_valid_o,
  input  logic                   gnt_ready_i,
  output logic                   scan_done_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  arb_state_e         state;
  logic [WIDTH-1:0]   mask;
  logic [WIDTH-1:0]   cand;
  logic [WIDTH-1:0]   pick_gnt;
  logic [Y_WIDTH-1:0] pick_idx;
  logic               pick_any;
  logic [WIDTH-1:0]   mask_above;
  logic               more;
  logic               xfer;

  assign cand = (arb_mode_e'(mode_i) == ARB_FIXED) ?
                req_i : (req_i & mask);

  y_prio_pick #(
    .WIDTH   (WIDTH),
    .Y_WIDTH (Y_WIDTH)
  ) u_pick (
    .req_i (cand),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Ones strictly above the one-hot grant; zero for the top column.
  assign mask_above = ~(gnt_o | (gnt_o - ONE));

  assign xfer = (state == ST_HOLD) && gnt_ready_i;

`ifdef Y_WRR_ARBITER_WEIGHT_EN
  logic [WGT_W-1:0] credit;
  logic [WGT_W-1:0] wgt_pick;
  logic [WGT_W-1:0] credit_load;

  assign wgt_pick    = weight_i[pick_idx*WGT_W +: WGT_W];
  assign credit_load = (wgt_pick == '0) ? WGT_W'(1) : wgt_pick;
  // Stay on the column only while it still asks for more.
  assign more = (credit > WGT_W'(1)) && req_i[yadd_o];

  always_ff @(posedge clk_i) begin
    if (reset_i || !enable_i) begin
      credit <= WGT_W'(1);
    end else if (state == ST_ARB && pick_any) begin
      credit <= credit_load;
    end else if (xfer) begin
      credit <= more ? (credit - WGT_W'(1)) : WGT_W'(1);
    end
  end
`else
  logic unused_weight;
  assign unused_weight = ^weight_i;
  assign more = 1'b0;
`endif

  // Dropping enable_i acts like reset and wins over a transfer.
  always_ff @(posedge clk_i) begin
    if (reset_i || !enable_i) begin
      state       <= ST_IDLE;
      mask        <= '1;
      gnt_o       <= '0;
      yadd_o      <= '0;
      gnt_valid_o <= 1'b0;
      scan_done_o <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          scan_done_o <= 1'b0;
          state       <= ST_ARB;
        end
        ST_ARB: begin
          if (pick_any) begin
            gnt_o       <= pick_gnt;
            yadd_o      <= pick_idx;
            gnt_valid_o <= 1'b1;
            state       <= ST_HOLD;
          end else begin
            scan_done_o <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_HOLD: begin
          if (xfer && !more) begin
            mask        <= mask_above;
            gnt_o       <= '0;
            yadd_o      <= '0;
            gnt_valid_o <= 1'b0;
            state       <= ST_ARB;
          end
        end
        ST_DONE: begin
          scan_done_o <= 1'b0;
          mask        <= '1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y_wrr_arbiter.sv
// Randomized and directed bench for y_wrr_arbiter against a
// scan-position reference model.
module tb_y_wrr_arbiter;

  localparam int W  = 8;
  localparam int YW = 3;
  localparam int WW = 2;
  localparam int WB = W * WW;

  localparam int P_IDLE = 0;
  localparam int P_ARB  = 1;
  localparam int P_HOLD = 2;
  localparam int P_DONE = 3;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          enable_i;
  logic [W-1:0]  req_i;
  logic          mode_i;
  logic [WB-1:0] weight_i;
  logic [W-1:0]  gnt_o;
  logic [YW-1:0] yadd_o;
  logic          gnt_valid_o;
  logic          gnt_ready_i;
  logic          scan_done_o;

  int checks = 0;
  int errors = 0;

  int m_ph;
  int m_from;
  int m_col;
  int m_left;
  bit m_valid;
  bit m_done;
  int xlog[$];

  always #5 clk = ~clk;

  y_wrr_arbiter #(
    .WIDTH   (W),
    .Y_WIDTH (YW),
    .WGT_W   (WW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .req_i       (req_i),
    .mode_i      (mode_i),
    .weight_i    (weight_i),
    .gnt_o       (gnt_o),
    .yadd_o      (yadd_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_ready_i (gnt_ready_i),
    .scan_done_o (scan_done_o)
  );

  task automatic chk(input string tag,
                     input int unsigned got,
                     input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int burst_of(input int c);
    int w;
    w = int'(weight_i[c*WW +: WW]);
`ifdef Y_WRR_ARBITER_WEIGHT_EN
    return (w == 0) ? 1 : w;
`else
    w = 1;
    return w;
`endif
  endfunction

  // m_from: lowest column still eligible in this scan (W = none).
  task automatic model_edge();
    int c;
    if (reset_i || !enable_i) begin
      m_ph = P_IDLE; m_from = 0; m_left = 1;
      m_valid = 0; m_done = 0;
    end else begin
      case (m_ph)
        P_IDLE: begin
          m_ph = P_ARB; m_done = 0;
        end
        P_ARB: begin
          c = -1;
          for (int i = 0; i < W; i++)
            if (c < 0 && req_i[i] && (mode_i || i >= m_from))
              c = i;
          if (c >= 0) begin
            m_col = c; m_left = burst_of(c);
            m_valid = 1; m_ph = P_HOLD;
          end else begin
            m_done = 1; m_ph = P_DONE;
          end
        end
        P_HOLD: begin
          if (gnt_ready_i) begin
            if (m_left > 1 && req_i[m_col]) begin
              m_left--;
            end else begin
              m_from = m_col + 1; m_valid = 0; m_ph = P_ARB;
            end
          end
        end
        default: begin
          m_done = 0; m_from = 0; m_ph = P_IDLE;
        end
      endcase
    end
  endtask

  task automatic step();
    bit xfer;
    int ycur;
    xfer = gnt_valid_o && gnt_ready_i && !reset_i;
    ycur = int'(yadd_o);
    @(posedge clk);
    model_edge();
    if (xfer) xlog.push_back(ycur);
    #1;
    chk("valid", gnt_valid_o, m_valid);
    chk("done", scan_done_o, m_done);
    if (m_valid) begin
      chk("gnt", gnt_o, 1 << m_col);
      chk("yadd", yadd_o, m_col);
    end else if (m_ph == P_IDLE) begin
      chk("gnt_idle", gnt_o, 0);
      chk("yadd_idle", yadd_o, 0);
    end
  endtask

  task automatic run_until_done(input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      if (scan_done_o) ok = 1;
    end
    if (!ok) chk("timeout_done", 0, 1);
  endtask

  task automatic run_until_valid(input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      if (gnt_valid_o) ok = 1;
    end
    if (!ok) chk("timeout_valid", 0, 1);
  endtask

  task automatic go_idle();
    enable_i = 0;
    step();
    xlog.delete();
  endtask

  initial begin
    int exp_seq[3];
    int nexp;
    int n0;
    int n7;
    int nv;
    bit hit;

    reset_i = 1; enable_i = 0; req_i = '0; mode_i = 0;
    weight_i = 16'h5555; gnt_ready_i = 0;
    step();
    step();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_valid", gnt_valid_o, 0);
    chk("rst_done", scan_done_o, 0);
    reset_i = 0;
    go_idle();

    // Round-robin scan 2, 5, 7 then done.
    req_i = 8'b1010_0100; gnt_ready_i = 1; enable_i = 1;
    run_until_done(30);
    exp_seq[0] = 2; exp_seq[1] = 5; exp_seq[2] = 7;
    chk("s1_count", xlog.size(), 3);
    for (int i = 0; i < 3 && i < xlog.size(); i++)
      chk("s1_seq", xlog[i], exp_seq[i]);
    go_idle();

    // Burst of weight 3 on column 3.
    weight_i = 16'h55D5; req_i = 8'b0000_1000; enable_i = 1;
    run_until_done(30);
`ifdef Y_WRR_ARBITER_WEIGHT_EN
    nexp = 3;
`else
    nexp = 1;
`endif
    chk("s2_count", xlog.size(), nexp);
    foreach (xlog[i]) chk("s2_col", xlog[i], 3);
    go_idle();

    // Hold under backpressure while the request drops.
    weight_i = 16'h5555; req_i = 8'b0000_0010;
    gnt_ready_i = 0; enable_i = 1;
    run_until_valid(10);
    req_i = '0;
    repeat (4) begin
      step();
      chk("s3_hold_gnt", gnt_o, 2);
      chk("s3_hold_valid", gnt_valid_o, 1);
    end
    chk("s3_no_xfer", xlog.size(), 0);
    gnt_ready_i = 1;
    step();
    chk("s3_xfer", xlog.size(), 1);
    if (xlog.size() > 0) chk("s3_xfer_col", xlog[0], 1);
    go_idle();

    // Fixed priority: column 0 always wins.
    mode_i = 1; req_i = 8'b1000_0001; enable_i = 1;
    repeat (40) step();
    n0 = 0; n7 = 0;
    foreach (xlog[i]) begin
      if (xlog[i] == 0) n0++;
      if (xlog[i] == 7) n7++;
    end
    chk("s4_col7", n7, 0);
    chk("s4_col0_all", n0, xlog.size());
    chk("s4_col0_many", (n0 >= 10) ? 1 : 0, 1);
    mode_i = 0;
    go_idle();

    // Enable falls mid-scan; restart from column 0.
    req_i = 8'hFF; enable_i = 1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      if (gnt_valid_o && yadd_o == 3'd2) hit = 1;
    end
    chk("s5_reach2", hit, 1);
    enable_i = 0;
    step();
    chk("s5_off_valid", gnt_valid_o, 0);
    chk("s5_off_gnt", gnt_o, 0);
    chk("s5_off_done", scan_done_o, 0);
    enable_i = 1;
    run_until_valid(10);
    chk("s5_restart", yadd_o, 0);
    go_idle();

    // Empty request: ARB then a single done pulse.
    req_i = '0; enable_i = 1;
    nv = 0; hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step();
      if (gnt_valid_o) nv++;
      if (scan_done_o) hit = 1;
    end
    chk("s6_done_seen", hit, 1);
    chk("s6_no_valid", nv, 0);
    step();
    chk("s6_one_pulse", scan_done_o, 0);
    go_idle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) req_i = W'($urandom);
      gnt_ready_i = ($urandom_range(9) < 7);
      enable_i = ($urandom_range(19) != 0);
      if ($urandom_range(29) == 0) mode_i = ~mode_i;
      if ($urandom_range(49) == 0) weight_i = WB'($urandom);
      reset_i = ($urandom_range(199) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
